// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles big-endian 32-bit words and writes them to instruction memory.
// Optional FILL_INVALID_EN pads unwritten words with INVALID_WORD after the session ends.
module instr_mem_loader #(
   parameter int          MEM_HEIGHT   = 32,
   parameter logic [31:0] INVALID_WORD = 32'hFC000000
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        in_valid,
   input  logic [7:0]                  in_data,
   input  logic                        in_last,
   output logic                        in_ready,
   output logic                        wr_en,
   output logic [31:0]                 wr_addr,
   output logic [31:0]                 wr_data,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [$clog2(MEM_HEIGHT):0] word_count
);

   localparam int CW = $clog2(MEM_HEIGHT) + 1;
   localparam logic [CW-1:0] LAST_IDX = CW'(MEM_HEIGHT - 1);

`ifdef FILL_INVALID_EN
   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE, S_FILL} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_WRITE, S_DONE} state_t;
`endif

   state_t        state_q, state_n;
   logic [1:0]    byte_idx_q, byte_idx_n;
   logic [CW-1:0] word_idx_q, word_idx_n;
   logic [CW-1:0] count_q, count_n;
   logic [23:0]   asm_q, asm_n;
   logic          last_q, last_n;
   logic          error_q, error_n;
   logic          wr_en_q, wr_en_n;
   logic [31:0]   wr_addr_q, wr_addr_n;
   logic [31:0]   wr_data_q, wr_data_n;

   function automatic logic [31:0] addr_of(input logic [CW-1:0] idx);
      return 32'(idx) << 2;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         byte_idx_q <= '0;
         word_idx_q <= '0;
         count_q    <= '0;
         asm_q      <= '0;
         last_q     <= 1'b0;
         error_q    <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_n;
         byte_idx_q <= byte_idx_n;
         word_idx_q <= word_idx_n;
         count_q    <= count_n;
         asm_q      <= asm_n;
         last_q     <= last_n;
         error_q    <= error_n;
         wr_en_q    <= wr_en_n;
         wr_addr_q  <= wr_addr_n;
         wr_data_q  <= wr_data_n;
      end
   end

   always_comb begin
      state_n    = state_q;
      byte_idx_n = byte_idx_q;
      word_idx_n = word_idx_q;
      count_n    = count_q;
      asm_n      = asm_q;
      last_n     = last_q;
      error_n    = error_q;
      wr_en_n    = 1'b0;
      wr_addr_n  = wr_addr_q;
      wr_data_n  = wr_data_q;

      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_n    = S_COLLECT;
               byte_idx_n = '0;
               word_idx_n = '0;
               count_n    = '0;
               last_n     = 1'b0;
               error_n    = 1'b0;
               asm_n      = INVALID_WORD[31:8];
            end
         end
         S_COLLECT: begin
            if (in_valid) begin
               byte_idx_n = byte_idx_q + 2'd1;
               case (byte_idx_q)
                  2'd0:    asm_n[23:16] = in_data;
                  2'd1:    asm_n[15:8]  = in_data;
                  2'd2:    asm_n[7:0]   = in_data;
                  default: ;
               endcase
               if (byte_idx_q == 2'd3) begin
                  // The fourth byte goes straight into the write register, saving a cycle.
                  state_n   = S_WRITE;
                  last_n    = in_last;
                  wr_en_n   = 1'b1;
                  wr_addr_n = addr_of(word_idx_q);
                  wr_data_n = {asm_q, in_data};
                  if (!in_last && word_idx_q == LAST_IDX)
                     error_n = 1'b1;
               end else if (in_last) begin
                  error_n    = 1'b1;
                  byte_idx_n = '0;
`ifdef FILL_INVALID_EN
                  state_n    = S_FILL;
                  wr_en_n    = 1'b1;
                  wr_addr_n  = addr_of(word_idx_q);
                  wr_data_n  = INVALID_WORD;
`else
                  state_n    = S_DONE;
`endif
               end
            end
         end
         S_WRITE: begin
            word_idx_n = word_idx_q + 1'b1;
            count_n    = count_q + 1'b1;
            if (last_q || word_idx_q == LAST_IDX) begin
`ifdef FILL_INVALID_EN
               if (word_idx_q != LAST_IDX) begin
                  state_n   = S_FILL;
                  wr_en_n   = 1'b1;
                  wr_addr_n = addr_of(word_idx_q + 1'b1);
                  wr_data_n = INVALID_WORD;
               end else begin
                  state_n   = S_DONE;
               end
`else
               state_n = S_DONE;
`endif
            end else begin
               state_n = S_COLLECT;
            end
         end
`ifdef FILL_INVALID_EN
         S_FILL: begin
            // word_idx_q is the index being written in this cycle.
            if (word_idx_q == LAST_IDX) begin
               state_n    = S_DONE;
            end else begin
               word_idx_n = word_idx_q + 1'b1;
               wr_en_n    = 1'b1;
               wr_addr_n  = addr_of(word_idx_q + 1'b1);
               wr_data_n  = INVALID_WORD;
            end
         end
`endif
         default: state_n = S_IDLE;
      endcase
   end

   assign in_ready   = (state_q == S_COLLECT);
   assign busy       = !((state_q == S_IDLE) || (state_q == S_DONE));
   assign done       = (state_q == S_DONE);
   assign error      = error_q;
   assign word_count = count_q;
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Bench for instr_mem_loader: per-cycle comparison against a queue-based model plus literal checks.
module tb_instr_mem_loader;
   localparam int MH = 32;
   localparam int CW = 6;
`ifdef FILL_INVALID_EN
   localparam bit FILL = 1'b1;
`else
   localparam bit FILL = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          in_valid = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_last = 1'b0;
   logic          in_ready, wr_en, busy, done, error;
   logic [31:0]   wr_addr, wr_data;
   logic [CW-1:0] word_count;

   instr_mem_loader #(.MEM_HEIGHT(MH), .INVALID_WORD(32'hFC000000)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .busy(busy), .done(done), .error(error), .word_count(word_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: expected writes queued in emission order, one per cycle.
   typedef struct packed { logic [31:0] addr; logic [31:0] data; logic fill; } wr_t;
   typedef struct packed { logic [31:0] a; logic [31:0] d; } lg_t;
   wr_t        wq[$];
   logic [7:0] mb[$];
   lg_t        wlog[$];
   int         m_words = 0, m_count = 0;
   bit         m_run = 0, m_end = 0, m_err = 0, m_done = 0, seen_rst = 0;
   logic [31:0] h_addr = 0, h_data = 0;
   bit         e_we, e_rdy;
   wr_t        cur;

   always @(negedge clk) begin
      e_we = (wq.size() > 0);
      if (e_we) cur = wq[0];
      else cur = '{addr: h_addr, data: h_data, fill: 1'b0};
      e_rdy = m_run && !m_end && (wq.size() == 0);
      if (seen_rst) begin
         chk("wr_en",      32'(wr_en),      32'(e_we));
         chk("in_ready",   32'(in_ready),   32'(e_rdy));
         chk("busy",       32'(busy),       32'(m_run));
         chk("done",       32'(done),       32'(m_done));
         chk("error",      32'(error),      32'(m_err));
         chk("word_count", 32'(word_count), 32'(m_count));
         chk("wr_addr",    wr_addr,         cur.addr);
         chk("wr_data",    wr_data,         cur.data);
      end
      if (wr_en === 1'b1) wlog.push_back('{a: wr_addr, d: wr_data});
      if (rst) begin
         wq.delete(); mb.delete();
         m_words = 0; m_count = 0; m_run = 0; m_end = 0; m_err = 0; m_done = 0;
         h_addr = 0; h_data = 0; seen_rst = 1;
      end else begin
         if (e_we) begin
            h_addr = cur.addr; h_data = cur.data;
            if (!cur.fill) m_count++;
            void'(wq.pop_front());
         end
         if (e_rdy && in_valid) begin
            mb.push_back(in_data);
            if (mb.size() == 4) begin
               wq.push_back('{addr: 32'(m_words * 4), data: {mb[0], mb[1], mb[2], mb[3]}, fill: 1'b0});
               m_words++;
               mb.delete();
               if (in_last) m_end = 1;
               else if (m_words == MH) begin m_end = 1; m_err = 1; end
            end else if (in_last) begin
               mb.delete(); m_end = 1; m_err = 1;
            end
            if (m_end && FILL)
               for (int i = m_words; i < MH; i++)
                  wq.push_back('{addr: 32'(i * 4), data: 32'hFC000000, fill: 1'b1});
         end
         if (!m_run && start) begin
            m_run = 1; m_end = 0; m_err = 0; m_done = 0; m_count = 0; m_words = 0; mb.delete();
         end else if (m_run && m_end && wq.size() == 0) begin
            m_run = 0; m_done = 1;
         end
      end
   end

   task automatic sync();
      @(posedge clk); #1;
   endtask

   task automatic pulse_start();
      sync(); start = 1'b1; sync(); start = 1'b0;
   endtask

   task automatic send(input logic [7:0] d, input bit last, input bit gap);
      int n = 0;
      in_data = d; in_last = last; in_valid = 1'b1;
      @(negedge clk);
      while (in_ready !== 1'b1 && n < 50) begin n++; @(negedge clk); end
      chk("send_accept", 32'(n < 50), 32'd1);
      sync();
      in_valid = 1'b0; in_last = 1'b0;
      if (gap) sync();
   endtask

   task automatic send_word(input logic [31:0] w, input bit last, input bit gap);
      send(w[31:24], 1'b0, gap);
      send(w[23:16], 1'b0, gap);
      send(w[15:8],  1'b0, gap);
      send(w[7:0],   last, gap);
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (done !== 1'b1 && n < 300) begin n++; @(negedge clk); end
      chk("done_wait", 32'(n < 300), 32'd1);
   endtask

   function automatic logic [31:0] ovf_word(input int w);
      logic [7:0] b;
      b = 8'(w);
      return {b, 8'hA5, 8'h5A, ~b};
   endfunction

   initial begin
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_wr_en",    32'(wr_en),    32'd0);
      chk("rst_busy",     32'(busy),     32'd0);
      chk("rst_done",     32'(done),     32'd0);
      chk("rst_error",    32'(error),    32'd0);
      chk("rst_count",    32'(word_count), 32'd0);
      chk("rst_wr_addr",  wr_addr,       32'd0);
      chk("rst_wr_data",  wr_data,       32'd0);

      // Two-word program, continuous valid
      sync(); wlog.delete();
      pulse_start();
      send_word(32'h20110009, 1'b0, 1'b0);
      send_word(32'h20080000, 1'b1, 1'b0);
      wait_done();
      chk("t1_nwr",   32'(wlog.size()), FILL ? 32'd32 : 32'd2);
      chk("t1_a0",    wlog[0].a, 32'h0);
      chk("t1_d0",    wlog[0].d, 32'h20110009);
      chk("t1_a1",    wlog[1].a, 32'h4);
      chk("t1_d1",    wlog[1].d, 32'h20080000);
      chk("t1_err",   32'(error), 32'd0);
      chk("t1_count", 32'(word_count), 32'd2);

      // Same program with toggling valid; start from DONE, and a stray start mid-session
      sync(); wlog.delete();
      pulse_start();
      send(8'h20, 1'b0, 1'b1);
      send(8'h11, 1'b0, 1'b1);
      pulse_start();
      send(8'h00, 1'b0, 1'b1);
      send(8'h09, 1'b0, 1'b1);
      send_word(32'h20080000, 1'b1, 1'b1);
      wait_done();
      chk("t2_a0",    wlog[0].a, 32'h0);
      chk("t2_d0",    wlog[0].d, 32'h20110009);
      chk("t2_d1",    wlog[1].d, 32'h20080000);
      chk("t2_count", 32'(word_count), 32'd2);

      // in_last on the sixth byte
      sync(); wlog.delete();
      pulse_start();
      send_word(32'h20110009, 1'b0, 1'b1);
      send(8'h20, 1'b0, 1'b1);
      send(8'h08, 1'b1, 1'b1);
      wait_done();
      chk("t3_nwr",   32'(wlog.size()), FILL ? 32'd32 : 32'd1);
      chk("t3_a0",    wlog[0].a, 32'h0);
      chk("t3_d0",    wlog[0].d, 32'h20110009);
      chk("t3_err",   32'(error), 32'd1);
      chk("t3_count", 32'(word_count), 32'd1);
`ifdef FILL_INVALID_EN
      chk("t3_fill_a", wlog[31].a, 32'h7C);
      chk("t3_fill_d", wlog[31].d, 32'hFC000000);
`endif

      // Overflow: 32 words accepted, a 33rd refused
      sync(); wlog.delete();
      pulse_start();
      for (int w = 0; w < MH; w++) send_word(ovf_word(w), 1'b0, 1'b0);
      wait_done();
      sync();
      in_data = 8'h77; in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t4_no_ready", 32'(in_ready), 32'd0);
      end
      sync(); in_valid = 1'b0;
      chk("t4_nwr",   32'(wlog.size()), 32'd32);
      chk("t4_alast", wlog[31].a, 32'h7C);
      chk("t4_dlast", wlog[31].d, 32'h1FA55AE0);
      chk("t4_err",   32'(error), 32'd1);
      chk("t4_count", 32'(word_count), 32'd32);

      // Reset mid-word, then a fresh one-word session
      sync(); wlog.delete();
      pulse_start();
      send(8'h20, 1'b0, 1'b0);
      send(8'h11, 1'b0, 1'b0);
      rst = 1'b1; sync(); rst = 1'b0;
      @(negedge clk);
      chk("t5_nwr",     32'(wlog.size()), 32'd0);
      chk("t5_busy",    32'(busy),  32'd0);
      chk("t5_ready",   32'(in_ready), 32'd0);
      chk("t5_wr_data", wr_data, 32'd0);
      sync();
      pulse_start();
      send_word(32'hDEADBEEF, 1'b1, 1'b0);
      wait_done();
      chk("t5_a0",    wlog[0].a, 32'h0);
      chk("t5_d0",    wlog[0].d, 32'hDEADBEEF);
      chk("t5_err",   32'(error), 32'd0);
      chk("t5_count", 32'(word_count), 32'd1);

      @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
